// File: rtl/key_event_pkg.sv
// Shared types and constants for the keyboard event queue.
package key_event_pkg;

  localparam int unsigned DefStableCycles = 16;
  localparam int unsigned DefFifoDepth    = 4;

  localparam logic [7:0] KEY_1   = 8'h1E;
  localparam logic [7:0] KEY_2   = 8'h1F;
  localparam logic [7:0] KEY_ESC = 8'h29;

  typedef struct packed {
    logic [7:0] code;
    logic       press;
  } key_event_t;

  typedef enum logic [1:0] {
    StIdle,
    StEmitRel,
    StEmitPress
  } emit_state_e;

endpackage

// File: rtl/key_event_fifo.sv
// Event FIFO with registered head outputs and a sticky drop flag.
module key_event_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [8:0]               push_data_i,
  input  logic                     pop_i,
  output logic [8:0]               head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [8:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic [8:0]      head_q, head_d;
  logic            ovf_q, ovf_d;
  logic            do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q + PtrW'(do_push);
    rd_d    = rd_q + PtrW'(do_pop);
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    ovf_d   = ovf_q | (push_i && full_o && !do_pop);
    // Head holds its last value when the queue drains.
    head_d  = head_q;
    if (count_d != '0) begin
      head_d = (do_push && (rd_d == wr_q)) ? push_data_i : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head_o     = head_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/key_event_queue.sv
// Two-slot keycode debouncer that turns committed key changes into
// release/press events queued for the consumer.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int unsigned StableCycles = DefStableCycles,
  parameter int unsigned FifoDepth    = DefFifoDepth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [7:0]                   keycode_i,
  input  logic [7:0]                   keycode2_i,
  input  logic                         evt_ready_i,
  output logic [7:0]                   stable_keycode_o,
  output logic [7:0]                   stable_keycode2_o,
  output logic                         evt_valid_o,
  output logic [7:0]                   evt_code_o,
  output logic                         evt_press_o,
  output logic [$clog2(FifoDepth):0]   fifo_count_o,
  output logic                         overflow_o
);

  localparam logic [7:0] StableCnt = 8'(StableCycles);

  logic [1:0][7:0] raw, stable_q, stable_d, cand_q, cand_n, cand_d, cnt_q, cnt_n, cnt_d;
  logic [1:0]      elig, commit;

  emit_state_e state_q;
  logic        slot_q, push_q;
  logic [7:0]  old_q, new_q, other_stable;
  logic [8:0]  push_data_q, head;
  logic        fifo_empty, fifo_full_unused;

  assign raw = {keycode2_i, keycode_i};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      cand_n[s] = cand_q[s];
      cnt_n[s]  = cnt_q[s];
      if (raw[s] == stable_q[s]) begin
        cnt_n[s] = '0;
      end else if (raw[s] != cand_q[s]) begin
        cand_n[s] = raw[s];
        cnt_n[s]  = 8'd1;
      end else if (cnt_q[s] < StableCnt) begin
        cnt_n[s] = cnt_q[s] + 8'd1;
      end
      elig[s] = (cnt_n[s] == StableCnt);
    end
    // Slot 0 wins a tie; slot 1 stays saturated until the emitter is idle again.
    commit[0] = (state_q == StIdle) && elig[0];
    commit[1] = (state_q == StIdle) && elig[1] && !elig[0];
    stable_d  = stable_q;
    cand_d    = cand_n;
    cnt_d     = cnt_n;
    for (int s = 0; s < 2; s++) begin
      if (commit[s]) begin
        stable_d[s] = cand_n[s];
        cnt_d[s]    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign other_stable = slot_q ? stable_q[0] : stable_q[1];

  // A code still held by the other slot is neither released nor re-pressed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      slot_q      <= 1'b0;
      old_q       <= '0;
      new_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          push_q <= 1'b0;
          if (|commit) begin
            slot_q  <= commit[1];
            old_q   <= stable_q[commit[1]];
            new_q   <= cand_n[commit[1]];
            state_q <= StEmitRel;
          end
        end
        StEmitRel: begin
          push_q      <= (old_q != 8'h00) && (old_q != other_stable);
          push_data_q <= {old_q, 1'b0};
          state_q     <= StEmitPress;
        end
        StEmitPress: begin
          push_q      <= (new_q != 8'h00) && (new_q != other_stable);
          push_data_q <= {new_q, 1'b1};
          state_q     <= StIdle;
        end
        default: begin
          push_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  key_event_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_q),
    .push_data_i(push_data_q),
    .pop_i      (evt_ready_i),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full_unused),
    .count_o    (fifo_count_o),
    .overflow_o (overflow_o)
  );

  assign stable_keycode_o  = stable_q[0];
  assign stable_keycode2_o = stable_q[1];
  assign evt_valid_o       = !fifo_empty;
  assign evt_code_o        = head[8:1];
  assign evt_press_o       = head[0];

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue.
module tb_key_event_queue;
  import key_event_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kc, kc2;
  logic       ready;
  logic [7:0] stable, stable2, evt_code;
  logic       evt_valid, evt_press, overflow;
  logic [2:0] count;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [8:0]  ev_log[$];
  bit          log_en = 1'b0;

  key_event_queue dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .keycode_i        (kc),
    .keycode2_i       (kc2),
    .evt_ready_i      (ready),
    .stable_keycode_o (stable),
    .stable_keycode2_o(stable2),
    .evt_valid_o      (evt_valid),
    .evt_code_o       (evt_code),
    .evt_press_o      (evt_press),
    .fifo_count_o     (count),
    .overflow_o       (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (log_en && !rst && evt_valid && ready) ev_log.push_back({evt_code, evt_press});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [7:0] code, input logic press);
    chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
    chk({tag, ".code"}, 32'(evt_code), 32'(code));
    chk({tag, ".press"}, 32'(evt_press), 32'(press));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".stable"}, 32'(stable), 32'h00);
    chk({tag, ".stable2"}, 32'(stable2), 32'h00);
    chk({tag, ".valid"}, 32'(evt_valid), 32'd0);
    chk({tag, ".code"}, 32'(evt_code), 32'h00);
    chk({tag, ".press"}, 32'(evt_press), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kc  = 8'h00;
    kc2 = 8'h00;
    #1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  // Four events queued: P1E, P1F, R1E, P29.
  task automatic fill_four();
    kc = KEY_1;
    tick(22);
    kc2 = KEY_2;
    tick(22);
    kc = KEY_ESC;
    tick(22);
  endtask

  initial begin
    rst   = 1'b1;
    kc    = 8'h00;
    kc2   = 8'h00;
    ready = 1'b0;
    tick(1);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single press: stable on edge 16, event at head on edge 19.
    kc = KEY_1;
    tick(15);
    chk("press.stable_e15", 32'(stable), 32'h00);
    tick(1);
    chk("press.stable_e16", 32'(stable), 32'h1E);
    chk("press.count_e16", 32'(count), 32'd0);
    tick(2);
    chk("press.valid_e18", 32'(evt_valid), 32'd0);
    tick(1);
    chk_head("press.e19", KEY_1, 1'b1);
    chk("press.count_e19", 32'(count), 32'd1);
    pop_one();
    chk("pop.count", 32'(count), 32'd0);
    chk("pop.valid", 32'(evt_valid), 32'd0);
    chk("pop.code_hold", 32'(evt_code), 32'h1E);
    pop_one();
    chk("pop_empty.count", 32'(count), 32'd0);
    chk("pop_empty.valid", 32'(evt_valid), 32'd0);
    chk("pop_empty.code_hold", 32'(evt_code), 32'h1E);

    // Release of 0x1E.
    kc = 8'h00;
    tick(20);
    chk_head("release", KEY_1, 1'b0);
    chk("release.count", 32'(count), 32'd1);
    pop_one();

    // Bouncing input never commits.
    for (int i = 0; i < 20; i++) begin
      kc = (i % 2 == 0) ? KEY_1 : 8'h00;
      tick(5);
    end
    kc = 8'h00;
    chk("bounce.stable", 32'(stable), 32'h00);
    chk("bounce.count", 32'(count), 32'd0);

    // Simultaneous change on both slots with consumer ready.
    log_en = 1'b1;
    ready  = 1'b1;
    kc     = KEY_ESC;
    kc2    = KEY_2;
    tick(16);
    chk("dual.stable_e16", 32'(stable), 32'h29);
    chk("dual.stable2_e16", 32'(stable2), 32'h00);
    tick(2);
    chk("dual.stable2_e18", 32'(stable2), 32'h00);
    tick(1);
    chk("dual.stable2_e19", 32'(stable2), 32'h1F);
    tick(10);
    chk("dual.nevents", 32'(ev_log.size()), 32'd2);
    if (ev_log.size() == 2) begin
      chk("dual.ev0", 32'(ev_log[0]), 32'({KEY_ESC, 1'b1}));
      chk("dual.ev1", 32'(ev_log[1]), 32'({KEY_2, 1'b1}));
    end
    chk("dual.count", 32'(count), 32'd0);
    log_en = 1'b0;
    ready  = 1'b0;

    // Overflow: six events into a depth-4 FIFO with no consumer.
    do_reset();
    fill_four();
    chk("ovf.count_full", 32'(count), 32'd4);
    chk("ovf.flag_before", 32'(overflow), 32'd0);
    kc2 = 8'h04;
    tick(22);
    chk("ovf.count", 32'(count), 32'd4);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk_head("ovf.h0", KEY_1, 1'b1);
    pop_one();
    chk_head("ovf.h1", KEY_2, 1'b1);
    pop_one();
    chk_head("ovf.h2", KEY_1, 1'b0);
    pop_one();
    chk_head("ovf.h3", KEY_ESC, 1'b1);
    pop_one();
    chk("ovf.valid_end", 32'(evt_valid), 32'd0);
    chk("ovf.count_end", 32'(count), 32'd0);
    chk("ovf.sticky", 32'(overflow), 32'd1);

    // Full FIFO with push and pop on the same edges.
    do_reset();
    chk("pp.flag_cleared", 32'(overflow), 32'd0);
    fill_four();
    chk("pp.count_full", 32'(count), 32'd4);
    kc2 = 8'h04;
    tick(17);
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    chk("pp.count", 32'(count), 32'd4);
    chk("pp.flag", 32'(overflow), 32'd0);
    chk_head("pp.h0", KEY_1, 1'b0);
    pop_one();
    chk_head("pp.h1", KEY_ESC, 1'b1);
    pop_one();
    chk_head("pp.h2", KEY_2, 1'b0);
    pop_one();
    chk_head("pp.h3", 8'h04, 1'b1);
    pop_one();
    chk("pp.valid_end", 32'(evt_valid), 32'd0);

    // Reset mid-debounce with events queued.
    do_reset();
    kc = KEY_1;
    tick(22);
    kc2 = KEY_2;
    tick(22);
    chk("mid.count_before", 32'(count), 32'd2);
    kc2 = KEY_1;
    tick(10);
    rst = 1'b1;
    kc  = 8'h00;
    #1;
    chk_reset_outputs("mid_reset");
    tick(1);
    rst = 1'b0;
    tick(15);
    chk("mid.stable2_e15", 32'(stable2), 32'h00);
    chk("mid.count_e15", 32'(count), 32'd0);
    chk("mid.valid_e15", 32'(evt_valid), 32'd0);
    tick(1);
    chk("mid.stable2_e16", 32'(stable2), 32'h1E);
    tick(3);
    chk_head("mid.e19", KEY_1, 1'b1);
    chk("mid.count_e19", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
